// File: rtl/mem_xfer_pkg.sv
// rtl/mem_xfer_pkg.sv - shared op codes, FSM states and word width for the transfer engine
package mem_xfer_pkg;

   localparam int WORD_WIDTH = 32;

   typedef enum logic [1:0] {
      OP_COPY = 2'd0,
      OP_FILL = 2'd1,
      OP_CMP  = 2'd2,
      OP_RSVD = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // A copy into a higher address walks downward so overlapping regions behave like memmove.
   function automatic logic copy_backward(input op_e op,
                                          input logic [WORD_WIDTH-1:0] src,
                                          input logic [WORD_WIDTH-1:0] dst);
      return (op == OP_COPY) && (dst > src);
   endfunction

endpackage

// File: rtl/mem_xfer_engine_if.sv
// rtl/mem_xfer_engine_if.sv - command handshake, result and memory port bundle of the transfer engine
interface mem_xfer_engine_if
   import mem_xfer_pkg::*;
#(
   parameter int LEN_WIDTH = 16
) ();

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [1:0]            cmd_op;
   logic [WORD_WIDTH-1:0] cmd_src;
   logic [WORD_WIDTH-1:0] cmd_dst;
   logic [LEN_WIDTH-1:0]  cmd_len;
   logic [WORD_WIDTH-1:0] cmd_fill;

   logic                  busy;
   logic                  done;
   logic                  result_mismatch;
   logic [LEN_WIDTH-1:0]  result_index;

   logic [WORD_WIDTH-1:0] read_address_0;
   logic [WORD_WIDTH-1:0] read_address_1;
   logic [WORD_WIDTH-1:0] read_data_0;
   logic [WORD_WIDTH-1:0] read_data_1;
   logic [WORD_WIDTH-1:0] write_address;
   logic [WORD_WIDTH-1:0] write_data;
   logic                  write_enable;

   // The engine is the memory-side master; the CPU control path and memory form the slave side.
   modport master (
      input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_len, cmd_fill,
      input  read_data_0, read_data_1,
      output cmd_ready, busy, done, result_mismatch, result_index,
      output read_address_0, read_address_1, write_address, write_data, write_enable
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_len, cmd_fill,
      output read_data_0, read_data_1,
      input  cmd_ready, busy, done, result_mismatch, result_index,
      input  read_address_0, read_address_1, write_address, write_data, write_enable
   );

endinterface

// File: rtl/xfer_addr_gen.sv
// rtl/xfer_addr_gen.sv - word offset counter, direction, region address adders and last-word flag
module xfer_addr_gen
   import mem_xfer_pkg::*;
#(
   parameter int LEN_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  start_backward,
   input  logic [LEN_WIDTH-1:0]  start_len,
   input  logic                  step,
   input  logic [LEN_WIDTH-1:0]  len,
   input  logic [WORD_WIDTH-1:0] src,
   input  logic [WORD_WIDTH-1:0] dst,
   output logic [LEN_WIDTH-1:0]  i,
   output logic [WORD_WIDTH-1:0] src_addr,
   output logic [WORD_WIDTH-1:0] dst_addr,
   output logic                  last
);

   localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);

   logic                 backward_q;
   logic [LEN_WIDTH-1:0] i_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         backward_q <= 1'b0;
         i_q        <= '0;
      end else if (start) begin
         backward_q <= start_backward;
         i_q        <= start_backward ? (start_len - ONE) : '0;
      end else if (step) begin
         i_q        <= backward_q ? (i_q - ONE) : (i_q + ONE);
      end
   end

   // Offsets are zero-extended; the 32-bit sums wrap naturally across the top of memory.
   assign i        = i_q;
   assign src_addr = src + WORD_WIDTH'(i_q);
   assign dst_addr = dst + WORD_WIDTH'(i_q);
   assign last     = backward_q ? (i_q == '0) : (i_q == (len - ONE));

endmodule

// File: rtl/mem_xfer_engine.sv
// rtl/mem_xfer_engine.sv - block copy/fill/compare initiator driving dual-read, single-write memory
module mem_xfer_engine
   import mem_xfer_pkg::*;
#(
   parameter int LEN_WIDTH = 16
) (
   input logic               clk,
   input logic               rst,
   mem_xfer_engine_if.master bus
);

   state_e                state_q, state_d;
   op_e                   op_q;
   op_e                   cmd_op;
   logic [WORD_WIDTH-1:0] src_q, dst_q, fill_q;
   logic [LEN_WIDTH-1:0]  len_q;
   logic                  mismatch_q;
   logic [LEN_WIDTH-1:0]  index_q;

   logic                  accept;
   logic                  running;
   logic                  is_cmp;
   logic                  words_differ;
   logic                  last;
   logic [LEN_WIDTH-1:0]  i;
   logic [WORD_WIDTH-1:0] src_addr, dst_addr;

   assign cmd_op       = op_e'(bus.cmd_op);
   assign accept       = (state_q == IDLE) && bus.cmd_valid;
   assign running      = (state_q == RUN);
   assign is_cmp       = (op_q == OP_CMP);
   assign words_differ = (bus.read_data_0 != bus.read_data_1);

   xfer_addr_gen #(
      .LEN_WIDTH (LEN_WIDTH)
   ) u_addr_gen (
      .clk            (clk),
      .rst            (rst),
      .start          (accept),
      .start_backward (copy_backward(cmd_op, bus.cmd_src, bus.cmd_dst)),
      .start_len      (bus.cmd_len),
      .step           (running),
      .len            (len_q),
      .src            (src_q),
      .dst            (dst_q),
      .i              (i),
      .src_addr       (src_addr),
      .dst_addr       (dst_addr),
      .last           (last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         op_q       <= OP_COPY;
         src_q      <= '0;
         dst_q      <= '0;
         len_q      <= '0;
         fill_q     <= '0;
         mismatch_q <= 1'b0;
         index_q    <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q       <= cmd_op;
            src_q      <= bus.cmd_src;
            dst_q      <= bus.cmd_dst;
            len_q      <= bus.cmd_len;
            fill_q     <= bus.cmd_fill;
            mismatch_q <= 1'b0;
            index_q    <= '0;
         end else if (running && is_cmp && words_differ) begin
            mismatch_q <= 1'b1;
            index_q    <= i;
         end
      end
   end

   // Empty and reserved commands skip RUN so they can never touch memory.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.cmd_valid) begin
               if ((bus.cmd_len == '0) || (cmd_op == OP_RSVD)) state_d = DONE;
               else                                            state_d = RUN;
            end
         end
         RUN: begin
            if ((is_cmp && words_differ) || last) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.read_address_0 = '0;
      bus.read_address_1 = '0;
      bus.write_address  = '0;
      bus.write_data     = '0;
      bus.write_enable   = 1'b0;
      if (running) begin
         case (op_q)
            OP_COPY: begin
               bus.read_address_0 = src_addr;
               bus.write_address  = dst_addr;
               bus.write_data     = bus.read_data_0;
               bus.write_enable   = 1'b1;
            end
            OP_FILL: begin
               bus.write_address  = dst_addr;
               bus.write_data     = fill_q;
               bus.write_enable   = 1'b1;
            end
            OP_CMP: begin
               bus.read_address_0 = src_addr;
               bus.read_address_1 = dst_addr;
            end
            default: ;
         endcase
      end
   end

   assign bus.cmd_ready       = (state_q == IDLE);
   assign bus.busy            = (state_q != IDLE);
   assign bus.done            = (state_q == DONE);
   assign bus.result_mismatch = mismatch_q;
   assign bus.result_index    = index_q;

endmodule

// File: tb/tb_mem_xfer_engine.sv
// tb/tb_mem_xfer_engine.sv - scoreboard bench for mem_xfer_engine with a small behavioural memory
module tb_mem_xfer_engine;
   import mem_xfer_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_xfer_engine_if #(.LEN_WIDTH(16)) bus ();
   mem_xfer_engine #(.LEN_WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

   logic [31:0] mem [0:1023];
   logic        bd_we   = 1'b0;
   logic [31:0] bd_addr = '0;
   logic [31:0] bd_data = '0;

   assign bus.read_data_0 = mem[bus.read_address_0[9:0]];
   assign bus.read_data_1 = mem[bus.read_address_1[9:0]];

   always @(posedge clk) begin
      if (bus.write_enable) mem[bus.write_address[9:0]] <= bus.write_data;
      if (bd_we)            mem[bd_addr[9:0]]           <= bd_data;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit          is_done;
      logic [31:0] addr;
      logic [31:0] data;
      int          cyc;
      logic        mm;
      logic [15:0] idx;
   } ev_t;
   ev_t exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic exp_wr(input logic [31:0] addr, input logic [31:0] data, input int c);
      ev_t e;
      e.is_done = 1'b0; e.addr = addr; e.data = data; e.cyc = c; e.mm = 1'b0; e.idx = '0;
      exp_q.push_back(e);
   endtask

   task automatic exp_done(input int c, input logic mm, input logic [15:0] idx);
      ev_t e;
      e.is_done = 1'b1; e.addr = '0; e.data = '0; e.cyc = c; e.mm = mm; e.idx = idx;
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin
      ev_t e;
      if (bus.write_enable) begin
         checks++;
         if (exp_q.size() == 0 || exp_q[0].is_done) begin
            errors++;
            $display("FAIL wr_unexpected: write addr %08h data %08h at cycle %0d, none expected",
                     bus.write_address, bus.write_data, cyc);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", bus.write_address, e.addr);
            check("wr_data", bus.write_data, e.data);
            check("wr_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
      if (bus.done) begin
         checks++;
         if (exp_q.size() == 0 || !exp_q[0].is_done) begin
            errors++;
            $display("FAIL done_unexpected: done at cycle %0d, none expected", cyc);
         end else begin
            e = exp_q.pop_front();
            check("done_cycle", 32'(cyc), 32'(e.cyc));
            check("done_mismatch", 32'(bus.result_mismatch), 32'(e.mm));
            check("done_index", 32'(bus.result_index), 32'(e.idx));
         end
      end
   end

   task automatic poke(input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      bd_addr = addr; bd_data = data; bd_we = 1'b1;
      @(posedge clk);
      #1 bd_we = 1'b0;
   endtask

   task automatic start_cmd(input logic [1:0] op, input logic [31:0] src, input logic [31:0] dst,
                            input logic [15:0] len, input logic [31:0] fill, output int a);
      int n = 0;
      @(negedge clk);
      while (!bus.cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!bus.cmd_ready) begin
         errors++;
         $display("FAIL cmd_ready_timeout: got 0 expected 1 within 100 cycles");
      end
      bus.cmd_op = op; bus.cmd_src = src; bus.cmd_dst = dst;
      bus.cmd_len = len; bus.cmd_fill = fill; bus.cmd_valid = 1'b1;
      a = cyc + 1;
   endtask

   task automatic end_cmd(input int hold);
      repeat (hold + 1) @(negedge clk);
      bus.cmd_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_timeout: %0d events pending, expected 0", name, exp_q.size());
         exp_q.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not reach its summary");
      $fatal(1);
   end

   initial begin
      int a;
      // A command presented during reset must be dropped.
      bus.cmd_valid = 1'b1; bus.cmd_op = OP_FILL; bus.cmd_src = '0;
      bus.cmd_dst = 32'd500; bus.cmd_len = 16'd1; bus.cmd_fill = 32'h55;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      bus.cmd_valid = 1'b0;
      check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_we", 32'(bus.write_enable), 32'd0);
      check("rst_ra0", bus.read_address_0, 32'd0);
      check("rst_ra1", bus.read_address_1, 32'd0);
      check("rst_wa", bus.write_address, 32'd0);
      check("rst_wd", bus.write_data, 32'd0);
      check("rst_mismatch", 32'(bus.result_mismatch), 32'd0);
      check("rst_index", 32'(bus.result_index), 32'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_dropped_cmd", 32'(bus.busy), 32'd0);

      for (int k = 0; k < 4; k++) poke(32'(100 + k), 32'(k + 1));

      // COPY up to a higher address runs backward: 203,202,201,200.
      start_cmd(OP_COPY, 32'd100, 32'd200, 16'd4, 32'd0, a);
      exp_wr(32'd203, 32'd4, a);
      exp_wr(32'd202, 32'd3, a + 1);
      exp_wr(32'd201, 32'd2, a + 2);
      exp_wr(32'd200, 32'd1, a + 3);
      exp_done(a + 4, 1'b0, 16'd0);
      end_cmd(0);
      drain("copy");
      for (int k = 0; k < 4; k++) check("copy_mem", mem[200 + k], 32'(k + 1));

      start_cmd(OP_COPY, 32'd100, 32'd101, 16'd4, 32'd0, a);
      exp_wr(32'd104, 32'd4, a);
      exp_wr(32'd103, 32'd3, a + 1);
      exp_wr(32'd102, 32'd2, a + 2);
      exp_wr(32'd101, 32'd1, a + 3);
      exp_done(a + 4, 1'b0, 16'd0);
      end_cmd(0);
      drain("overlap");
      for (int k = 0; k < 4; k++) check("overlap_mem", mem[101 + k], 32'(k + 1));
      check("overlap_src0", mem[100], 32'd1);

      // FILL across the top of memory with cmd_valid held high and fields changed while busy.
      start_cmd(OP_FILL, 32'd0, 32'hFFFF_FFFE, 16'd3, 32'hDEAD_BEEF, a);
      exp_wr(32'hFFFF_FFFE, 32'hDEAD_BEEF, a);
      exp_wr(32'hFFFF_FFFF, 32'hDEAD_BEEF, a + 1);
      exp_wr(32'h0000_0000, 32'hDEAD_BEEF, a + 2);
      exp_done(a + 3, 1'b0, 16'd0);
      @(negedge clk);
      bus.cmd_dst = 32'd300; bus.cmd_len = 16'd1;
      check("fill_busy", 32'(bus.busy), 32'd1);
      check("fill_not_ready", 32'(bus.cmd_ready), 32'd0);
      end_cmd(2);
      drain("fill");

      for (int k = 0; k < 4; k++) poke(32'(100 + k), 32'(k + 1));
      poke(32'd200, 32'd1); poke(32'd201, 32'd2); poke(32'd202, 32'd9); poke(32'd203, 32'd4);
      start_cmd(OP_CMP, 32'd100, 32'd200, 16'd4, 32'd0, a);
      exp_done(a + 3, 1'b1, 16'd2);
      end_cmd(0);
      drain("cmp_mismatch");
      check("cmp_hold_mismatch", 32'(bus.result_mismatch), 32'd1);
      check("cmp_hold_index", 32'(bus.result_index), 32'd2);
      check("cmp_mem_untouched", mem[202], 32'd9);

      start_cmd(OP_COPY, 32'd100, 32'd200, 16'd0, 32'd0, a);
      exp_done(a, 1'b0, 16'd0);
      end_cmd(0);
      drain("len0");

      start_cmd(OP_RSVD, 32'd100, 32'd200, 16'd4, 32'd0, a);
      exp_done(a, 1'b0, 16'd0);
      end_cmd(0);
      drain("reserved");

      start_cmd(OP_CMP, 32'd100, 32'd200, 16'd2, 32'd0, a);
      exp_done(a + 2, 1'b0, 16'd0);
      end_cmd(0);
      drain("cmp_match");

      // Reset in the second RUN cycle: two backward words land, no done.
      for (int k = 0; k < 4; k++) poke(32'(200 + k), 32'(32'hA0 + k));
      start_cmd(OP_COPY, 32'd100, 32'd200, 16'd4, 32'd0, a);
      exp_wr(32'd203, 32'd4, a);
      exp_wr(32'd202, 32'd3, a + 1);
      end_cmd(0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_busy", 32'(bus.busy), 32'd0);
      check("midrst_ready", 32'(bus.cmd_ready), 32'd1);
      check("midrst_we", 32'(bus.write_enable), 32'd0);
      rst = 1'b0;
      drain("midrst");
      repeat (5) @(negedge clk);
      check("midrst_mem203", mem[203], 32'd4);
      check("midrst_mem202", mem[202], 32'd3);
      check("midrst_mem201", mem[201], 32'hA1);
      check("midrst_mem200", mem[200], 32'hA0);

      start_cmd(OP_FILL, 32'd0, 32'd300, 16'd1, 32'd5, a);
      exp_wr(32'd300, 32'd5, a);
      exp_done(a + 1, 1'b0, 16'd0);
      end_cmd(0);
      drain("recover");
      check("recover_mem", mem[300], 32'd5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_xfer_engine.md
# mem_xfer_engine

Block-transfer initiator that drives the dual-port main memory interface from the master side. Accepts one command at a time (copy, fill, or compare) over a valid/ready handshake and sequences one memory word per cycle using read ports 0/1 and the single write port. Sits between the CPU control path and main memory as a small DMA engine, and returns a done pulse plus a compare result.

## Interface
- `LEN_WIDTH`, 16: width of the transfer length and the result index.
- `clk` in 1: sole clock, all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: engine idle, so the command is accepted this cycle if `cmd_valid`.
- `cmd_op` in 2: operation code. 0 COPY, 1 FILL, 2 CMP, 3 reserved.
- `cmd_src` in 32: source word address. Unused by FILL.
- `cmd_dst` in 32: destination word address. For CMP, the second region.
- `cmd_len` in LEN_WIDTH: number of words.
- `cmd_fill` in 32: FILL pattern.
- `busy` out 1: command in progress.
- `done` out 1: one-cycle completion pulse.
- `result_mismatch` out 1: last CMP found a difference.
- `result_index` out LEN_WIDTH: word offset of the first CMP mismatch.
- `read_address_0` out 32: memory read port 0 address.
- `read_address_1` out 32: memory read port 1 address.
- `read_data_0` in 32: memory read port 0 data, combinational from the address.
- `read_data_1` in 32: memory read port 1 data, combinational from the address.
- `write_address` out 32: memory write address.
- `write_data` out 32: memory write data.
- `write_enable` out 1: write committed by memory at the next posedge.

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN on `cmd_valid && cmd_ready`. Latch op, src, dst, len, fill and clear the result registers.
- If latched len is 0 or op is 3, go IDLE → DONE directly with no memory writes.
- RUN performs one word per cycle. The counter `i` steps 0..len-1 (ascending), except for backward COPY.
- Backward COPY: when `dst > src` (unsigned), `i` steps len-1..0. This gives memmove semantics for overlapping regions.
- COPY: `read_address_0` = src+i, `write_address` = dst+i, `write_data` = `read_data_0` (combinational pass-through), `write_enable` = 1.
- FILL: `write_address` = dst+i, `write_data` = fill, `write_enable` = 1.
- CMP: `read_address_0` = src+i, `read_address_1` = dst+i, `write_enable` = 0.
  - On `read_data_0 != read_data_1`: set `result_mismatch`=1 and `result_index`=i, then go to DONE immediately.
- RUN → DONE after the last word is processed.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `busy` = (state != IDLE). `cmd_ready` = (state == IDLE).
- Address arithmetic is 32-bit, wrapping modulo 2^32. Length arithmetic is LEN_WIDTH-bit.
- Result registers hold their value until the next command is accepted.
- Outside RUN: `write_enable`=0, and both read addresses and `write_address` are held at 0.

## Timing
- Reset values: state IDLE, `cmd_ready`=1, `busy`=0, `done`=0, `write_enable`=0, all addresses 0, `write_data`=0, `result_mismatch`=0, `result_index`=0.
- Accept edge t0. Word k is issued in cycle t0+1+k, and its write lands at the end of that cycle.
- `done` is high in cycle t0+1+len. `cmd_ready` returns high in cycle t0+2+len.
- Zero-length command: `done` is high in cycle t0+1.
- CMP mismatch at offset m: `done` is high in cycle t0+2+m.
- Every output except `write_data` in COPY is a function of registers only. No input-to-output combinational path exists other than `read_data_0` → `write_data`.
- `cmd_valid` during `busy` is ignored (not accepted). The command is not queued.
- `rst` high mid-RUN: state is IDLE after that edge. The write issued in the reset cycle is still committed by memory at that edge. No later writes occur, and `done` is not pulsed.
- `rst` and `cmd_valid` both high in the same cycle: reset wins and the command is not accepted.

## Structure
- Package `mem_xfer_pkg` holds:
  - op encodings `OP_COPY`, `OP_FILL`, `OP_CMP`;
  - the state enum IDLE/RUN/DONE;
  - `WORD_WIDTH` = 32.
- Sub-module `xfer_addr_gen` holds the counter `i`, the direction bit, the src+i/dst+i adders, and the last-word flag.
- The top level holds the FSM, latches, and results.

## Test plan
- Memory preloaded with mem[100..103]=1,2,3,4. COPY src=100 dst=200 len=4 → mem[200..203]=1,2,3,4. `done` in cycle t0+5. Exactly 4 `write_enable` cycles.
- Overlapping COPY src=100 dst=101 len=4 (mem[100..103]=1,2,3,4) → mem[101..104]=1,2,3,4. Issue order is addresses 104,103,102,101.
- FILL dst=0xFFFFFFFE len=3 fill=0xDEADBEEF → writes to 0xFFFFFFFE, 0xFFFFFFFF, 0x0 (wrap-around).
- CMP src=100 dst=200 len=4 with mem[202]=9 and the other words equal → `result_mismatch`=1, `result_index`=2, `done` at t0+4, no writes.
- COPY len=0 → `done` at t0+1, no writes. `cmd_valid` held high during `busy` → exactly one command is accepted.
- Assert `rst` in the 2nd RUN cycle of COPY len=4 → at most 2 words written, `busy`=0 and `cmd_ready`=1 after reset, no `done` pulse.
